// File: rtl/mips_pkg.sv
// Shared constants, stage word type and elaboration helpers for the MIPS datapath selectors.
package mips_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_N_IN  = 4;

  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] dat;
  } stage_word_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage holding a valid bit and WIDTH data bits; flush clears, stall holds.
module pipe_stage_reg
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = 1'b0;
      dat_d = '0;
    end else if (!stall) begin
      vld_d = vld_i;
      dat_d = dat_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/mux_pipe_sel.sv
// N-way selector feeding a DEPTH-stage register chain with valid, stall, flush and illegal-key pulse.
// Optional accepted-item counter port acc_cnt when MUX_PIPE_SEL_PERF_EN is defined.
module mux_pipe_sel
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = DEF_N_IN,
  parameter int SEL_W = 2,
  parameter int DEPTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] entradas,
  input  logic [SEL_W-1:0]      key,
  input  logic                  valid_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      saida,
  output logic                  valid_out,
  output logic                  sel_err
`ifdef MUX_PIPE_SEL_PERF_EN
  ,
  output logic [15:0]           acc_cnt
`endif
);

  if (N_IN < 2 || DEPTH < 1 || SEL_W < clog2(N_IN)) begin : g_bad_param
    $error("mux_pipe_sel: illegal parameter combination");
  end

  logic [WIDTH-1:0] sel_data;
  logic             key_legal;
  logic             normal_edge;

  // Loop compare keeps out-of-range keys from indexing past the flattened bus.
  always_comb begin
    sel_data  = '0;
    key_legal = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (key == SEL_W'(i)) begin
        sel_data  = entradas[i*WIDTH +: WIDTH];
        key_legal = 1'b1;
      end
    end
  end

  assign normal_edge = !flush && !stall;

  logic [DEPTH:0]            vld_c;
  logic [DEPTH:0][WIDTH-1:0] dat_c;

  assign vld_c[0] = valid_in && key_legal;
  assign dat_c[0] = vld_c[0] ? sel_data : '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .vld_i (vld_c[k]),
      .dat_i (dat_c[k]),
      .vld_o (vld_c[k+1]),
      .dat_o (dat_c[k+1])
    );
  end

  assign saida     = dat_c[DEPTH];
  assign valid_out = vld_c[DEPTH];

  logic sel_err_q, sel_err_d;

  assign sel_err_d = normal_edge && valid_in && !key_legal;

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef MUX_PIPE_SEL_PERF_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (normal_edge && vld_c[0] && acc_cnt_q != 16'hFFFF) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
`endif

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed bench: DUT A (N_IN=4, DEPTH=2) and DUT B (N_IN=3, DEPTH=2) for the illegal-key path.
module tb_mux_pipe_sel;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [19:0] ent_a;
  logic [1:0]  key_a;
  logic        vin_a, stall_a, flush_a;
  logic [4:0]  saida_a;
  logic        vout_a, err_a;

  logic [14:0] ent_b;
  logic [1:0]  key_b;
  logic        vin_b, stall_b, flush_b;
  logic [4:0]  saida_b;
  logic        vout_b, err_b;

`ifdef MUX_PIPE_SEL_PERF_EN
  logic [15:0] acc_a, acc_b;
`endif

  int checks = 0;
  int errors = 0;

  mux_pipe_sel #(.WIDTH(5), .N_IN(4), .SEL_W(2), .DEPTH(2)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .entradas  (ent_a),
    .key       (key_a),
    .valid_in  (vin_a),
    .stall     (stall_a),
    .flush     (flush_a),
    .saida     (saida_a),
    .valid_out (vout_a),
    .sel_err   (err_a)
`ifdef MUX_PIPE_SEL_PERF_EN
    ,
    .acc_cnt   (acc_a)
`endif
  );

  mux_pipe_sel #(.WIDTH(5), .N_IN(3), .SEL_W(2), .DEPTH(2)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .entradas  (ent_b),
    .key       (key_b),
    .valid_in  (vin_b),
    .stall     (stall_b),
    .flush     (flush_b),
    .saida     (saida_b),
    .valid_out (vout_b),
    .sel_err   (err_b)
`ifdef MUX_PIPE_SEL_PERF_EN
    ,
    .acc_cnt   (acc_b)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    ent_a   = {5'd3, 5'd2, 5'd1, 5'd0};
    key_a   = 2'd0;
    vin_a   = 1'b0;
    stall_a = 1'b0;
    flush_a = 1'b0;
    ent_b   = {5'd2, 5'd1, 5'd0};
    key_b   = 2'd0;
    vin_b   = 1'b0;
    stall_b = 1'b0;
    flush_b = 1'b0;

    // Reset held for two edges, then released.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_saida", 16'(saida_a), 16'd0);
      check("rst_valid", 16'(vout_a), 16'd0);
      check("rst_err_b", 16'(err_b), 16'd0);
    end
    reset = 1'b0;
    step();
    check("post_rst_saida", 16'(saida_a), 16'd0);
    check("post_rst_valid", 16'(vout_a), 16'd0);

    // Streaming keys 0..3 back to back, then a bubble.
    for (int i = 0; i < 6; i++) begin
      vin_a = (i < 4);
      key_a = 2'(i);
      step();
      if (i == 0 || i == 5) begin
        check("stream_valid_idle", 16'(vout_a), 16'd0);
        check("stream_saida_idle", 16'(saida_a), 16'd0);
      end else begin
        check("stream_valid", 16'(vout_a), 16'd1);
        check("stream_saida", 16'(saida_a), 16'(i - 1));
      end
    end
    check("selerr_a_full", 16'(err_a), 16'd0);

    // Stall for three edges after accepting key 2; key 3 offered during stall.
    vin_a = 1'b1;
    key_a = 2'd2;
    step();
    check("stall_pre_valid", 16'(vout_a), 16'd0);
    stall_a = 1'b1;
    key_a   = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_valid", 16'(vout_a), 16'd0);
    end
    stall_a = 1'b0;
    vin_a   = 1'b0;
    step();
    check("stall_out_valid", 16'(vout_a), 16'd1);
    check("stall_out_saida", 16'(saida_a), 16'd2);
    step();
    check("stall_nocapture", 16'(vout_a), 16'd0);

    // Flush with two items in flight and a new request on the flush edge.
    vin_a = 1'b1;
    key_a = 2'd0;
    step();
    key_a = 2'd3;
    step();
    check("flush_pre_valid", 16'(vout_a), 16'd1);
    check("flush_pre_saida", 16'(saida_a), 16'd0);
    flush_a = 1'b1;
    key_a   = 2'd1;
    step();
    check("flush_valid0", 16'(vout_a), 16'd0);
    check("flush_saida0", 16'(saida_a), 16'd0);
    flush_a = 1'b0;
    vin_a   = 1'b0;
    step();
    check("flush_valid1", 16'(vout_a), 16'd0);
    step();
    check("flush_valid2", 16'(vout_a), 16'd0);

    // Illegal key on the 3-input instance.
    vin_b = 1'b1;
    key_b = 2'd3;
    step();
    check("illegal_err", 16'(err_b), 16'd1);
    key_b = 2'd2;
    step();
    check("illegal_err_clr", 16'(err_b), 16'd0);
    check("illegal_bubble", 16'(vout_b), 16'd0);
    vin_b = 1'b0;
    step();
    check("legal_after_valid", 16'(vout_b), 16'd1);
    check("legal_after_saida", 16'(saida_b), 16'd2);
    check("legal_after_err", 16'(err_b), 16'd0);

    // Reset mid-operation discards the in-flight item and holds outputs low.
    vin_a = 1'b1;
    key_a = 2'd1;
    step();
    step();
    check("midrst_pre_saida", 16'(saida_a), 16'd1);
    reset = 1'b1;
    step();
    check("midrst_valid", 16'(vout_a), 16'd0);
    check("midrst_saida", 16'(saida_a), 16'd0);
    step();
    check("midrst_hold", 16'(vout_a), 16'd0);
    reset = 1'b0;
    vin_a = 1'b0;
    step();
    check("midrst_after", 16'(vout_a), 16'd0);

`ifdef MUX_PIPE_SEL_PERF_EN
    reset = 1'b1;
    step();
    check("acc_rst", acc_b, 16'd0);
    reset = 1'b0;
    vin_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_b = 2'(i % 3);
      step();
    end
    key_b = 2'd3;
    step();
    key_b   = 2'd2;
    flush_b = 1'b1;
    step();
    flush_b = 1'b0;
    vin_b   = 1'b0;
    step();
    check("acc_count5", acc_b, 16'd5);

    vin_a = 1'b1;
    key_a = 2'd0;
    repeat (65534) step();
    check("acc_fffe", acc_a, 16'hFFFE);
    repeat (3) step();
    check("acc_sat", acc_a, 16'hFFFF);
    vin_a = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
